// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings for the CPU memory-bus arbiter: FSM states, bus owner and
// the saturating starvation-counter helper.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWaitRd = 2'd2,
        StDone   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OwnFetch = 1'b0,
        OwnData  = 1'b1
    } arb_owner_e;

    localparam int unsigned StarveCntW = 4;
    localparam logic [1:0]  FullMask   = 2'b11;

    function automatic logic [StarveCntW-1:0] starve_inc(input logic [StarveCntW-1:0] cnt,
                                                         input logic [StarveCntW-1:0] limit);
        return (cnt >= limit) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and load/store,
// one outstanding transaction at a time, with a starvation guard for fetch.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned BITS         = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    fetch_req,
    input  logic [ADDRESS_BITS-1:0] fetch_addr,
    output logic [BITS-1:0]         fetch_data,
    output logic                    fetch_ack,
    input  logic                    load_memory,
    input  logic                    store_memory,
    input  logic [ADDRESS_BITS-1:0] load_store_address,
    input  logic [BITS-1:0]         memory_out,
    input  logic [1:0]              memory_wr_mask,
    output logic [BITS-1:0]         ls_rdata,
    output logic                    ls_ack,
    output logic                    stall_pipeline,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    output logic [1:0]              mem_wr_mask,
    output logic                    mem_wr,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [BITS-1:0]         mem_rdata
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(STARVE_LIMIT);

    arb_state_e              state_q;
    arb_owner_e              owner_q;
    logic [StarveCntW-1:0]   starve_cnt_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [BITS-1:0]         wdata_q;
    logic [1:0]              mask_q;
    logic                    wr_q;
    logic                    valid_q;
    logic [BITS-1:0]         fetch_data_q;
    logic [BITS-1:0]         ls_rdata_q;
    logic                    fetch_ack_q;
    logic                    ls_ack_q;

    logic data_req;
    logic data_wins;

    assign data_req  = load_memory | store_memory;
    assign data_wins = data_req & (~fetch_req | (starve_cnt_q < Limit));

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q      <= StIdle;
            owner_q      <= OwnFetch;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= FullMask;
            wr_q         <= 1'b0;
            valid_q      <= 1'b0;
            fetch_data_q <= '0;
            ls_rdata_q   <= '0;
            fetch_ack_q  <= 1'b0;
            ls_ack_q     <= 1'b0;
        end else begin
            fetch_ack_q <= 1'b0;
            ls_ack_q    <= 1'b0;
            if (!fetch_req) begin
                starve_cnt_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (data_wins) begin
                        owner_q <= OwnData;
                        addr_q  <= load_store_address;
                        wdata_q <= store_memory ? memory_out : '0;
                        mask_q  <= memory_wr_mask;
                        wr_q    <= store_memory;
                        valid_q <= 1'b1;
                        state_q <= StIssue;
                        if (fetch_req) begin
                            starve_cnt_q <= starve_inc(starve_cnt_q, Limit);
                        end
                    end else if (fetch_req) begin
                        owner_q      <= OwnFetch;
                        addr_q       <= fetch_addr;
                        wdata_q      <= '0;
                        mask_q       <= FullMask;
                        wr_q         <= 1'b0;
                        valid_q      <= 1'b1;
                        state_q      <= StIssue;
                        starve_cnt_q <= '0;
                    end
                end
                StIssue: begin
                    if (mem_ready) begin
                        valid_q <= 1'b0;
                        // A read whose data comes back with the accept skips WAIT_RD.
                        if (wr_q || mem_rvalid) begin
                            if (!wr_q && owner_q == OwnFetch) fetch_data_q <= mem_rdata;
                            if (!wr_q && owner_q == OwnData)  ls_rdata_q   <= mem_rdata;
                            fetch_ack_q <= (owner_q == OwnFetch);
                            ls_ack_q    <= (owner_q == OwnData);
                            state_q     <= StDone;
                        end else begin
                            state_q <= StWaitRd;
                        end
                    end
                end
                StWaitRd: begin
                    if (mem_rvalid) begin
                        if (owner_q == OwnFetch) fetch_data_q <= mem_rdata;
                        else                     ls_rdata_q   <= mem_rdata;
                        fetch_ack_q <= (owner_q == OwnFetch);
                        ls_ack_q    <= (owner_q == OwnData);
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign fetch_data     = fetch_data_q;
    assign fetch_ack      = fetch_ack_q;
    assign ls_rdata       = ls_rdata_q;
    assign ls_ack         = ls_ack_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wr_mask    = mask_q;
    assign mem_wr         = wr_q;
    assign mem_valid      = valid_q;
    assign stall_pipeline = data_req & ~ls_ack_q;

endmodule
